// File: rtl/simple_mac_if.sv
// simple_mac_if: operand/result stream bundle for simple_mac.
//   Operand stream : in_valid_i, in_ready_o, data_a_i, data_b_i, last_i
//   Result stream  : out_valid_o, out_ready_i, result_o, ovf_o
// Signal suffixes are seen from the MAC: the slave modport is the MAC side,
// the master modport is the producer/consumer side.
interface simple_mac_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 24
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] data_a_i;
  logic [WIDTH-1:0] data_b_i;
  logic             last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RW-1:0]    result_o;
  logic             ovf_o;

  modport slave (
    input  in_valid_i, data_a_i, data_b_i, last_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, ovf_o
  );

  modport master (
    output in_valid_i, data_a_i, data_b_i, last_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, ovf_o
  );
endinterface

// File: rtl/simple_mac.sv
// simple_mac: two-stage pipelined multiply-accumulate.
//   Stage p1 registers the product of each accepted operand pair; stage p2
//   adds it into the group accumulator and, on the beat flagged last_i,
//   presents the group sum on a held valid/ready result stream.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - simple_mac_if.slave (operand stream in, result stream out)
// Parameters: WIDTH (operand bits), GUARD (accumulator guard bits),
//   SIGNED (0 = unsigned, 1 = two's complement). Result width RW = 2*WIDTH+GUARD.
// Build option: define SIMPLE_MAC_SATURATE_EN to clamp the accumulator on
//   overflow instead of wrapping; ovf_o flags the overflow either way.
module simple_mac #(
  parameter int WIDTH  = 8,
  parameter int GUARD  = 8,
  parameter int SIGNED = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  simple_mac_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int RW = PW + GUARD;

  // Overflow of a RW-bit add given both addends and the RW+1 bit raw sum.
  function automatic logic add_ovf(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                   input logic [RW:0] s);
    if (SIGNED == 0) return s[RW];
    return (a[RW-1] == b[RW-1]) && (s[RW-1] != a[RW-1]);
  endfunction

`ifdef SIMPLE_MAC_SATURATE_EN
  // Clamp toward the overflow direction; for signed adds both addends share
  // the sign, so the accumulator sign tells the direction.
  function automatic logic [RW-1:0] sat_sum(input logic [RW-1:0] s, input logic ovf,
                                            input logic neg);
    if (!ovf)        return s;
    if (SIGNED == 0) return '1;
    if (neg)         return {1'b1, {(RW-1){1'b0}}};
    return {1'b0, {(RW-1){1'b1}}};
  endfunction
`endif

  logic                 adv;
  logic                 accept;
  logic        [PW-1:0] prod_u;
  logic signed [PW-1:0] prod_s;
  logic        [RW-1:0] prod_ext;
  logic        [RW:0]   sum_raw;
  logic                 beat_ovf;
  logic        [RW-1:0] sum_sel;

  logic          vld_p1_q, vld_p1_d;
  logic          last_p1_q, last_p1_d;
  logic [RW-1:0] prod_p1_q, prod_p1_d;
  logic [RW-1:0] acc_p2_q, acc_p2_d;
  logic          grp_ovf_q, grp_ovf_d;
  logic          out_vld_q, out_vld_d;
  logic [RW-1:0] result_q, result_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    adv    = !out_vld_q || bus.out_ready_i;
    accept = bus.in_valid_i && adv;
  end

  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = out_vld_q;
  assign bus.result_o    = result_q;
  assign bus.ovf_o       = ovf_q;

  // ---- stage p0 -> p1: product, extended to the accumulator width ----
  always_comb begin
    prod_u   = PW'(bus.data_a_i) * PW'(bus.data_b_i);
    prod_s   = PW'($signed(bus.data_a_i)) * PW'($signed(bus.data_b_i));
    prod_ext = (SIGNED != 0) ? RW'(prod_s) : RW'(prod_u);
  end

  // ---- stage p1 -> p2: accumulate ----
  always_comb begin
    sum_raw  = {1'b0, acc_p2_q} + {1'b0, prod_p1_q};
    beat_ovf = add_ovf(acc_p2_q, prod_p1_q, sum_raw);
`ifdef SIMPLE_MAC_SATURATE_EN
    sum_sel  = sat_sum(sum_raw[RW-1:0], beat_ovf, acc_p2_q[RW-1]);
`else
    sum_sel  = sum_raw[RW-1:0];
`endif
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    prod_p1_d = prod_p1_q;
    acc_p2_d  = acc_p2_q;
    grp_ovf_d = grp_ovf_q;
    out_vld_d = out_vld_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    // Everything freezes while a result is held unconsumed.
    if (adv) begin
      vld_p1_d  = accept;
      last_p1_d = bus.last_i;
      prod_p1_d = prod_ext;
      // A consumed result drops valid unless a new group closes this cycle,
      // in which case the assignment below overrides it with no bubble.
      if (bus.out_ready_i) out_vld_d = 1'b0;
      if (vld_p1_q) begin
        if (last_p1_q) begin
          result_d  = sum_sel;
          ovf_d     = grp_ovf_q | beat_ovf;
          out_vld_d = 1'b1;
          acc_p2_d  = '0;
          grp_ovf_d = 1'b0;
        end else begin
          acc_p2_d  = sum_sel;
          grp_ovf_d = grp_ovf_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q  <= 1'b0;
      acc_p2_q  <= '0;
      grp_ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      acc_p2_q  <= acc_p2_d;
      grp_ovf_q <= grp_ovf_d;
      out_vld_q <= out_vld_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  // Product and last flag are qualified by vld_p1_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    prod_p1_q <= prod_p1_d;
    last_p1_q <= last_p1_d;
  end
endmodule

// File: tb/tb_simple_mac.sv
// tb_simple_mac: three simple_mac instances (unsigned GUARD=8, unsigned GUARD=0,
// signed GUARD=8) driven by one shared stimulus; a directed vector table and
// hand-written sequences plus a randomized phase checked against an
// arithmetic group-sum scoreboard.
module tb_simple_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       last;
  logic       out_ready;
  logic [7:0] da;
  logic [7:0] db;

  simple_mac_if #(.WIDTH(8), .RW(24)) if_u ();
  simple_mac_if #(.WIDTH(8), .RW(16)) if_g ();
  simple_mac_if #(.WIDTH(8), .RW(24)) if_s ();

  assign if_u.in_valid_i  = in_valid;
  assign if_u.data_a_i    = da;
  assign if_u.data_b_i    = db;
  assign if_u.last_i      = last;
  assign if_u.out_ready_i = out_ready;
  assign if_g.in_valid_i  = in_valid;
  assign if_g.data_a_i    = da;
  assign if_g.data_b_i    = db;
  assign if_g.last_i      = last;
  assign if_g.out_ready_i = out_ready;
  assign if_s.in_valid_i  = in_valid;
  assign if_s.data_a_i    = da;
  assign if_s.data_b_i    = db;
  assign if_s.last_i      = last;
  assign if_s.out_ready_i = out_ready;

  simple_mac #(.WIDTH(8), .GUARD(8), .SIGNED(0)) u_u (.clk_i(clk), .rst_i(rst), .bus(if_u));
  simple_mac #(.WIDTH(8), .GUARD(0), .SIGNED(0)) u_g (.clk_i(clk), .rst_i(rst), .bus(if_g));
  simple_mac #(.WIDTH(8), .GUARD(8), .SIGNED(1)) u_s (.clk_i(clk), .rst_i(rst), .bus(if_s));

  logic [23:0] res [3];
  logic        ov  [3];
  logic        ovld;
  logic        irdy;
  assign res[0] = if_u.result_o;
  assign res[1] = {8'h00, if_g.result_o};
  assign res[2] = if_s.result_o;
  assign ov[0]  = if_u.ovf_o;
  assign ov[1]  = if_g.ovf_o;
  assign ov[2]  = if_s.ovf_o;
  assign ovld   = if_u.out_valid_o;
  assign irdy   = if_u.in_ready_o;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain integer group sums ----------------
  typedef struct packed {
    logic [2:0][23:0] r;
    logic [2:0]       o;
  } exp_t;

  exp_t   expq[$];
  longint acc_m [3];
  bit     ovf_m [3];

  function automatic int rw_of(input int cfg);
    return (cfg == 1) ? 16 : 24;
  endfunction

  function automatic longint prod_of(input int cfg, input logic [7:0] a, input logic [7:0] b);
    if (cfg == 2) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      acc_m[c] = 0;
      ovf_m[c] = 1'b0;
    end
  endtask

  task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic lst);
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      longint m, lo, hi, s;
      m = longint'(1) << rw_of(c);
      if (c == 2) begin
        lo = -(m >> 1);
        hi = (m >> 1) - 1;
      end else begin
        lo = 0;
        hi = m - 1;
      end
      s = acc_m[c] + prod_of(c, a, b);
      if (s > hi || s < lo) begin
        ovf_m[c] = 1'b1;
`ifdef SIMPLE_MAC_SATURATE_EN
        s = (s > hi) ? hi : lo;
`else
        s = (s > hi) ? s - m : s + m;
`endif
      end
      acc_m[c] = s;
      e.r[c] = 24'(s & (m - 1));
      e.o[c] = ovf_m[c];
    end
    if (lst) begin
      expq.push_back(e);
      model_clear();
    end
  endtask

  // Scoreboard monitor: samples mid-cycle what the next rising edge will do.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_clear();
        expq.delete();
      end else begin
        if (ovld && out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got result %0h expected no result at %0t", res[0], $time);
          end else begin
            exp_t e;
            e = expq.pop_front();
            for (int c = 0; c < 3; c++) begin
              chk($sformatf("sb_result%0d", c), res[c], e.r[c]);
              chk($sformatf("sb_ovf%0d", c), 24'(ov[c]), 24'(e.o[c]));
            end
          end
        end
        if (in_valid && irdy) model_beat(da, db, last);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [23:0] r0, r1, r2;
    logic        o0, o1, o2;
  } vec_t;

  vec_t tbl [10];

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic lst);
    in_valid = 1'b1;
    da       = a;
    db       = b;
    last     = lst;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  initial begin : main
    bit found;
    tbl[0] = '{8'd3,   8'd4,   1'b0, 24'd0,      24'd0,     24'd0,      1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'd5,   8'd6,   1'b1, 24'd42,     24'd42,    24'd42,     1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'd255, 8'd255, 1'b1, 24'd65025,  24'd65025, 24'd1,      1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'd255, 8'd255, 1'b0, 24'd0,      24'd0,     24'd0,      1'b0, 1'b0, 1'b0};
`ifdef SIMPLE_MAC_SATURATE_EN
    tbl[4] = '{8'd255, 8'd255, 1'b1, 24'd130050, 24'd65535, 24'd2,      1'b0, 1'b1, 1'b0};
`else
    tbl[4] = '{8'd255, 8'd255, 1'b1, 24'd130050, 24'd64514, 24'd2,      1'b0, 1'b1, 1'b0};
`endif
    tbl[5] = '{8'd253, 8'd4,   1'b0, 24'd0,      24'd0,     24'd0,      1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'd2,   8'd5,   1'b1, 24'd1022,   24'd1022,  24'hFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'd128, 8'd128, 1'b0, 24'd0,      24'd0,     24'd0,      1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'd128, 8'd128, 1'b1, 24'd32768,  24'd32768, 24'd32768,  1'b0, 1'b0, 1'b0};
    tbl[9] = '{8'd0,   8'd200, 1'b1, 24'd0,      24'd0,     24'd0,      1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    last      = 1'b0;
    out_ready = 1'b1;
    da        = '0;
    db        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 24'(ovld), 24'd0);
    chk("rst_result", res[0], 24'd0);
    chk("rst_ovf", 24'(ov[0]), 24'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 24'(irdy), 24'd1);

    for (int i = 0; i < 10; i++) begin
      drive_beat(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) begin
        chk($sformatf("tbl%0d_valid_early", i), 24'(ovld), 24'd0);
        @(posedge clk);
        #1;
        chk($sformatf("tbl%0d_valid", i), 24'(ovld), 24'd1);
        chk($sformatf("tbl%0d_r_u", i), res[0], tbl[i].r0);
        chk($sformatf("tbl%0d_r_g0", i), res[1], tbl[i].r1);
        chk($sformatf("tbl%0d_r_s", i), res[2], tbl[i].r2);
        chk($sformatf("tbl%0d_o_u", i), 24'(ov[0]), 24'(tbl[i].o0));
        chk($sformatf("tbl%0d_o_g0", i), 24'(ov[1]), 24'(tbl[i].o1));
        chk($sformatf("tbl%0d_o_s", i), 24'(ov[2]), 24'(tbl[i].o2));
      end
    end

    // Backpressure: hold a result while a new beat waits at the input.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive_beat(8'd7, 8'd7, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_valid", 24'(ovld), 24'd1);
    in_valid = 1'b1;
    da       = 8'd1;
    db       = 8'd1;
    last     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 24'(irdy), 24'd0);
      chk("bp_result_hold", res[0], 24'd49);
      chk("bp_valid_hold", 24'(ovld), 24'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(posedge clk);
      #1;
      if (ovld) found = 1'b1;
    end
    chk("bp_queued_valid", 24'(found), 24'd1);
    chk("bp_queued_result", res[0], 24'd1);

    // Reset in the middle of a group discards the partial sum.
    @(posedge clk);
    #1;
    drive_beat(8'd10, 8'd10, 1'b0);
    drive_beat(8'd10, 8'd10, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 24'(ovld), 24'd0);
    chk("midrst_result", res[0], 24'd0);
    chk("midrst_ovf", 24'(ov[0]), 24'd0);
    rst = 1'b0;
    drive_beat(8'd1, 8'd1, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst_new_valid", 24'(ovld), 24'd1);
    chk("midrst_new_result", res[0], 24'd1);

    // Randomized traffic with random backpressure and rare resets.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      last      = ($urandom_range(0, 3) == 0);
      da        = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      db        = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    last      = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_pending", 24'(expq.size()), 24'd0);
    chk("drain_valid", 24'(ovld), 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
